m68k_bus_mem: RTL and testbench

- Parametrised, clocked 68000 bus slave that replaces the ad-hoc combinational ROM/RAM models in the CPU bench.
- Decodes ROM and RAM regions on the 68000 asynchronous-style bus, sampled synchronously, and generates DTACK after a configurable number of wait states.
- Honours UDS/LDS byte lanes.
- Raises BERR on unmapped accesses.
- Sits between wf68k00ip_top and the system memory map, in the bench and later in the FPGA build.

---
 rtl/m68k_bus_pkg.sv | 34 +++
 rtl/m68k_mem_lane_ram.sv | 24 ++
 rtl/m68k_bus_mem.sv | 147 ++++++++++++++
 tb/tb_m68k_bus_mem.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared 68000 bus slave definitions: FSM states, region codes and the address decode.
// Kept separate so future peripheral slaves on the same map can reuse the decode.
package m68k_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_BERR = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_ROM  = 2'd1,
        REG_RAM  = 2'd2
    } region_t;

    localparam int MAX_WAIT_STATES = 15;

    // Byte-address decode; limits are 25 bits wide so a region ending at 16 MiB does not wrap.
    function automatic region_t decode_region(input logic [23:0] a,
                                              input logic [24:0] rom_bytes,
                                              input logic [23:0] ram_base,
                                              input logic [24:0] ram_bytes);
        logic [24:0] a_w;
        a_w = {1'b0, a};
        if (a_w < rom_bytes)
            return REG_ROM;
        if ((a >= ram_base) && (a_w < ({1'b0, ram_base} + ram_bytes)))
            return REG_RAM;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/m68k_mem_lane_ram.sv
// Single-port 16-bit RAM with per-byte write enables and a registered read port.
// Contents start at zero and are never cleared by reset.
module m68k_mem_lane_ram #(
    parameter int DEPTH = 8192,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    be,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (be[1])
            mem[addr][15:8] <= wdata[15:8];
        if (be[0])
            mem[addr][7:0] <= wdata[7:0];
        rdata <= mem[addr];
    end

endmodule

// File: rtl/m68k_bus_mem.sv
// Clocked 68000 bus slave: ROM at byte 0, RAM at RAM_BASE, DTACK after WAIT_STATES, BERR if unmapped.
// Optional macro M68K_BUS_MEM_ROM_WP_EN: ROM writes raise BERR instead of being silently acknowledged.
module m68k_bus_mem
    import m68k_bus_pkg::*;
#(
    parameter int          ROM_WORDS   = 8192,
    parameter int          RAM_WORDS   = 8192,
    parameter logic [23:0] RAM_BASE    = 24'h014000,
    parameter int          WAIT_STATES = 0,
    parameter string       ROM_FILE    = "rom.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:1] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        as_n,
    input  logic        rw_n,
    input  logic        uds_n,
    input  logic        lds_n,
    output logic        dtack_n,
    output logic        berr_n
);

    localparam int          ROM_AW    = $clog2(ROM_WORDS);
    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [24:0] ROM_BYTES = 25'(2 * ROM_WORDS);
    localparam logic [24:0] RAM_BYTES = 25'(2 * RAM_WORDS);
    localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    if ((int'(RAM_BASE) < 2 * ROM_WORDS) || RAM_BASE[0] ||
        (WAIT_STATES < 0) || (WAIT_STATES > MAX_WAIT_STATES)) begin : g_param_err
        $error("m68k_bus_mem: RAM overlaps ROM, RAM_BASE unaligned or WAIT_STATES out of range");
    end

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [23:1] lat_addr;
    logic        lat_rw;
    logic [1:0]  lat_lanes;
    logic [15:0] lat_wdata;
    region_t     lat_region;

    region_t     cur_region;
    logic        strobe;
    logic        rom_wp;
    logic [23:1] idx_addr;
    logic [RAM_AW-1:0] ram_idx;
    logic [1:0]  ram_be;
    logic [15:0] ram_rdata;

    logic [15:0] rom [ROM_WORDS] = '{default: '0};

    assign strobe     = !as_n && (!uds_n || !lds_n);
    assign cur_region = decode_region({addr, 1'b0}, ROM_BYTES, RAM_BASE, RAM_BYTES);

`ifdef M68K_BUS_MEM_ROM_WP_EN
    assign rom_wp = (cur_region == REG_ROM) && !rw_n;
`else
    assign rom_wp = 1'b0;
`endif

    // RAM is addressed from the live bus while idle so its registered read is ready by the first ACK cycle.
    assign idx_addr = (state == S_IDLE) ? addr : lat_addr;
    assign ram_idx  = RAM_AW'(idx_addr - RAM_BASE[23:1]);

    // The write fires only in the first ACK cycle (dtack_n still high), so each lane is written once.
    assign ram_be = (state == S_ACK && dtack_n && !lat_rw && lat_region == REG_RAM && !reset)
                    ? lat_lanes : 2'b00;

    m68k_mem_lane_ram #(
        .DEPTH (RAM_WORDS),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_idx),
        .be    (ram_be),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (state == S_IDLE && strobe) begin
            lat_addr   <= addr;
            lat_rw     <= rw_n;
            lat_lanes  <= ~{uds_n, lds_n};
            lat_wdata  <= data_in;
            lat_region <= cur_region;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            dtack_n  <= 1'b1;
            berr_n   <= 1'b1;
            data_out <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    dtack_n <= 1'b1;
                    berr_n  <= 1'b1;
                    if (strobe) begin
                        if (cur_region == REG_NONE || rom_wp) begin
                            state <= S_BERR;
                        end else if (WAIT_STATES == 0) begin
                            state <= S_ACK;
                        end else begin
                            wait_cnt <= WS_LOAD;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (as_n)
                        state <= S_IDLE;
                    else if (wait_cnt == 4'd0)
                        state <= S_ACK;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                S_ACK: begin
                    if (dtack_n && lat_rw)
                        data_out <= (lat_region == REG_RAM) ? ram_rdata : rom[lat_addr[ROM_AW:1]];
                    if (as_n) begin
                        dtack_n <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        dtack_n <= 1'b0;
                    end
                end
                S_BERR: begin
                    dtack_n <= 1'b1;
                    if (as_n) begin
                        berr_n <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        berr_n <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_mem.sv
// Self-checking bench for m68k_bus_mem: one instance with no wait states, one with three.
// Both share the bus; only the instance whose as_n is driven low takes part in a cycle.
module tb_m68k_bus_mem;
    import m68k_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:1] addr;
    logic [15:0] data_in;
    logic        rw_n, uds_n, lds_n;
    logic [1:0]  as_n;
    logic [15:0] dout [2];
    logic [1:0]  dtack_n, berr_n;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    m68k_bus_mem #(.WAIT_STATES(0), .ROM_FILE("")) dut0 (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .data_out(dout[0]),
        .as_n(as_n[0]), .rw_n(rw_n), .uds_n(uds_n), .lds_n(lds_n),
        .dtack_n(dtack_n[0]), .berr_n(berr_n[0]));

    m68k_bus_mem #(.WAIT_STATES(3), .ROM_FILE("")) dut3 (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .data_out(dout[1]),
        .as_n(as_n[1]), .rw_n(rw_n), .uds_n(uds_n), .lds_n(lds_n),
        .dtack_n(dtack_n[1]), .berr_n(berr_n[1]));

    // Runs one bus cycle on instance sel; reports the edge (counted from the strobe sample) at which
    // dtack_n or berr_n fell, the read data, whether the response held, and whether it released.
    task automatic bus_cycle(input int sel, input logic [23:0] a, input logic rd_nwr,
                             input logic u_n, input logic l_n, input logic [15:0] wd,
                             input int abort_at, output int lat_d, output int lat_b,
                             output logic [15:0] rd, output logic hold_ok, output logic rel_ok);
        lat_d = 0; lat_b = 0; rd = 16'hxxxx; hold_ok = 1'b1; rel_ok = 1'b1;
        @(negedge clk);
        addr = a[23:1]; rw_n = rd_nwr; uds_n = u_n; lds_n = l_n; data_in = wd;
        as_n[sel] = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            if (!dtack_n[sel]) begin
                lat_d = n; rd = dout[sel];
                if (!berr_n[sel]) hold_ok = 1'b0;
                break;
            end
            if (!berr_n[sel]) begin
                lat_b = n;
                break;
            end
            if (n == abort_at) begin
                @(negedge clk);
                as_n[sel] = 1'b1;
            end
        end
        if (lat_d != 0 || lat_b != 0) begin
            for (int k = 0; k < 2; k++) begin
                @(posedge clk); #1;
                if (lat_d != 0 && (dtack_n[sel] !== 1'b0 || berr_n[sel] !== 1'b1)) hold_ok = 1'b0;
                if (lat_b != 0 && (berr_n[sel] !== 1'b0 || dtack_n[sel] !== 1'b1)) hold_ok = 1'b0;
            end
        end
        @(negedge clk);
        as_n[sel] = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(posedge clk); #1;
        rel_ok = (dtack_n[sel] === 1'b1) && (berr_n[sel] === 1'b1);
    endtask

    task automatic test_reset();
        total++; if (dtack_n !== 2'b11) begin bad++; $display("FAIL reset_dtack: got %b want 11", dtack_n); end
        total++; if (berr_n !== 2'b11) begin bad++; $display("FAIL reset_berr: got %b want 11", berr_n); end
        total++; if (dout[0] !== 16'h0000) begin bad++; $display("FAIL reset_dout0: got %h want 0000", dout[0]); end
        total++; if (dout[1] !== 16'h0000) begin bad++; $display("FAIL reset_dout3: got %h want 0000", dout[1]); end
        total++; if (dut0.state !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", dut0.state); end
    endtask

    task automatic test_rom_read();
        int ld, lb; logic [15:0] rd, e; logic h, r;
        logic [23:0] addrs [2] = '{24'h000000, 24'h000002};
        logic [15:0] words [2] = '{16'h0000, 16'h1000};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(words[i]);
            bus_cycle(0, addrs[i], 1'b1, 1'b0, 1'b0, 16'h0000, 0, ld, lb, rd, h, r);
            e = exp_q.pop_front();
            total++; if (ld != 1) begin bad++; $display("FAIL rom_lat%0d: got %0d want 1", i, ld); end
            total++; if (rd !== e) begin bad++; $display("FAIL rom_data%0d: got %h want %h", i, rd, e); end
            total++; if (!(h && r && lb == 0)) begin bad++; $display("FAIL rom_hs%0d: hold=%b rel=%b berr_edge=%0d want 1 1 0", i, h, r, lb); end
        end
    endtask

    task automatic test_ram_word();
        int ld, lb; logic [15:0] rd, e; logic h, r;
        bus_cycle(0, 24'h014000, 1'b0, 1'b0, 1'b0, 16'hBEEF, 0, ld, lb, rd, h, r);
        total++; if (ld != 1 || !h || !r) begin bad++; $display("FAIL ram_wr_ack: lat=%0d hold=%b rel=%b want 1 1 1", ld, h, r); end
        exp_q.push_back(16'hBEEF);
        bus_cycle(0, 24'h014000, 1'b1, 1'b0, 1'b0, 16'h0000, 0, ld, lb, rd, h, r);
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL ram_word: got %h want %h", rd, e); end
        // Last mapped RAM word sits right at the region boundary.
        bus_cycle(0, 24'h017FFE, 1'b0, 1'b0, 1'b0, 16'hA55A, 0, ld, lb, rd, h, r);
        exp_q.push_back(16'hA55A);
        bus_cycle(0, 24'h017FFE, 1'b1, 1'b0, 1'b0, 16'h0000, 0, ld, lb, rd, h, r);
        e = exp_q.pop_front();
        total++; if (rd !== e || ld != 1) begin bad++; $display("FAIL ram_top: got %h lat %0d want %h lat 1", rd, ld, e); end
    endtask

    task automatic test_lanes();
        int ld, lb; logic [15:0] rd, e; logic h, r;
        bus_cycle(0, 24'h014002, 1'b0, 1'b0, 1'b1, 16'h12AB, 0, ld, lb, rd, h, r);
        exp_q.push_back(16'h1200);
        bus_cycle(0, 24'h014002, 1'b1, 1'b1, 1'b0, 16'h0000, 0, ld, lb, rd, h, r);
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL lane_upper: got %h want %h", rd, e); end
        bus_cycle(0, 24'h014002, 1'b0, 1'b1, 1'b0, 16'hCD34, 0, ld, lb, rd, h, r);
        exp_q.push_back(16'h1234);
        bus_cycle(0, 24'h014002, 1'b1, 1'b0, 1'b1, 16'h0000, 0, ld, lb, rd, h, r);
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL lane_lower: got %h want %h", rd, e); end
    endtask

    task automatic test_wait_states();
        int ld, lb; logic [15:0] rd, e; logic h, r;
        exp_q.push_back(16'h1000);
        bus_cycle(1, 24'h000002, 1'b1, 1'b0, 1'b0, 16'h0000, 0, ld, lb, rd, h, r);
        e = exp_q.pop_front();
        total++; if (ld != 4) begin bad++; $display("FAIL ws3_lat: got %0d want 4", ld); end
        total++; if (rd !== e || !h || !r) begin bad++; $display("FAIL ws3_rom: got %h hold=%b rel=%b want %h 1 1", rd, h, r, e); end
        bus_cycle(1, 24'h014000, 1'b0, 1'b0, 1'b0, 16'h0A0A, 0, ld, lb, rd, h, r);
        total++; if (ld != 4) begin bad++; $display("FAIL ws3_wr_lat: got %0d want 4", ld); end
        // Abort after two cycles: strobe withdrawn while still waiting.
        bus_cycle(1, 24'h014000, 1'b0, 1'b0, 1'b0, 16'h5555, 2, ld, lb, rd, h, r);
        total++; if (ld != 0 || lb != 0 || !r) begin bad++; $display("FAIL abort_ack: dtack_edge=%0d berr_edge=%0d rel=%b want 0 0 1", ld, lb, r); end
        exp_q.push_back(16'h0A0A);
        bus_cycle(1, 24'h014000, 1'b1, 1'b0, 1'b0, 16'h0000, 0, ld, lb, rd, h, r);
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL abort_nowrite: got %h want %h", rd, e); end
    endtask

    task automatic test_unmapped();
        int ld, lb; logic [15:0] rd; logic h, r;
        logic [23:0] addrs [3] = '{24'h800000, 24'h004000, 24'h018000};
        for (int i = 0; i < 3; i++) begin
            bus_cycle(0, addrs[i], 1'b1, 1'b0, 1'b0, 16'h0000, 0, ld, lb, rd, h, r);
            total++; if (lb != 1 || ld != 0) begin bad++; $display("FAIL berr_edge%0d: berr=%0d dtack=%0d want 1 0", i, lb, ld); end
            total++; if (!h || !r) begin bad++; $display("FAIL berr_hold%0d: hold=%b rel=%b want 1 1", i, h, r); end
        end
    endtask

    task automatic test_rom_write();
        int ld, lb; logic [15:0] rd, e; logic h, r;
        bus_cycle(0, 24'h000000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 0, ld, lb, rd, h, r);
`ifdef M68K_BUS_MEM_ROM_WP_EN
        total++; if (lb != 1 || ld != 0) begin bad++; $display("FAIL rom_wr_resp: berr=%0d dtack=%0d want 1 0", lb, ld); end
`else
        total++; if (ld != 1 || lb != 0) begin bad++; $display("FAIL rom_wr_resp: dtack=%0d berr=%0d want 1 0", ld, lb); end
`endif
        exp_q.push_back(16'h0000);
        bus_cycle(0, 24'h000000, 1'b1, 1'b0, 1'b0, 16'h0000, 0, ld, lb, rd, h, r);
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL rom_wr_kept: got %h want %h", rd, e); end
    endtask

    task automatic test_back_to_back();
        int ld, lb; logic [15:0] rd, e; logic h, r;
        logic [15:0] model [4];
        logic [23:0] a;
        for (int i = 0; i < 4; i++) begin
            model[i] = 16'($urandom);
            a = 24'h014010 + 24'(2 * i);
            bus_cycle(0, a, 1'b0, 1'b0, 1'b0, model[i], 0, ld, lb, rd, h, r);
        end
        for (int i = 0; i < 4; i++) begin
            a = 24'h014010 + 24'(2 * i);
            exp_q.push_back(model[i]);
            bus_cycle(0, a, 1'b1, 1'b0, 1'b0, 16'h0000, 0, ld, lb, rd, h, r);
            e = exp_q.pop_front();
            total++; if (rd !== e || ld != 1) begin bad++; $display("FAIL b2b_%0d: got %h lat %0d want %h lat 1", i, rd, ld, e); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int ld, lb; logic [15:0] rd, e; logic h, r;
        logic [23:0] a = 24'h014004;
        @(negedge clk);
        addr = a[23:1]; rw_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; data_in = 16'h7777;
        as_n[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (dtack_n[1] !== 1'b1 || berr_n[1] !== 1'b1) begin bad++; $display("FAIL rst_wait_out: dtack=%b berr=%b want 1 1", dtack_n[1], berr_n[1]); end
        total++; if (dut3.state !== S_IDLE) begin bad++; $display("FAIL rst_wait_state: got %0d want IDLE", dut3.state); end
        total++; if (dout[1] !== 16'h0000) begin bad++; $display("FAIL rst_wait_dout: got %h want 0000", dout[1]); end
        @(negedge clk);
        reset = 1'b0; as_n = 2'b11; uds_n = 1'b1; lds_n = 1'b1;
        exp_q.push_back(16'h0000);
        bus_cycle(1, a, 1'b1, 1'b0, 1'b0, 16'h0000, 0, ld, lb, rd, h, r);
        e = exp_q.pop_front();
        total++; if (rd !== e || ld != 4) begin bad++; $display("FAIL rst_wait_lost: got %h lat %0d want %h lat 4", rd, ld, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; as_n = 2'b11; rw_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        addr = '0; data_in = '0;
        #1;
        dut0.rom[0] = 16'h0000; dut0.rom[1] = 16'h1000;
        dut3.rom[0] = 16'h0000; dut3.rom[1] = 16'h1000;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_rom_read();
        test_ram_word();
        test_lanes();
        test_wait_states();
        test_unmapped();
        test_rom_write();
        test_back_to_back();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
